heap_memory_server: RTL and testbench

- Responder end of the executor's heap access channel.
- Services single-outstanding read, write, resize and count-greater requests against a banked array heap.
- Owns per-array length tracking; length is updated here on every write rather than in the executor.
- Sits between the instruction-stepping fpga executor and an internal single-port synchronous RAM.

---
 rtl/heap_pkg.sv | 23 ++
 rtl/heap_ram.sv | 29 ++
 rtl/heap_memory_server.sv | 215 +++++++++++++++++++++
 tb/tb_heap_memory_server.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// rtl/heap_pkg.sv - shared heap channel types, FSM encodings and default sizes
package heap_pkg;

  localparam int HEAP_WORD_W   = 12;
  localparam int HEAP_N_AREA   = 4;
  localparam int HEAP_N_ARRAYS = 4;

  typedef enum logic [1:0] {
    READ          = 2'd0,
    WRITE         = 2'd1,
    COUNT_GREATER = 2'd2,
    RESIZE        = 2'd3
  } heap_op_t;

  typedef logic [2:0] heap_state_t;

  localparam heap_state_t ST_IDLE    = 3'd0;
  localparam heap_state_t ST_ACCESS  = 3'd1;
  localparam heap_state_t ST_SCAN    = 3'd2;
  localparam heap_state_t ST_RESPOND = 3'd3;
  localparam heap_state_t ST_CLEAR   = 3'd4;

endpackage

// File: rtl/heap_ram.sv
// rtl/heap_ram.sv - single-port synchronous RAM, registered read, write-through output
module heap_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only moves on an enabled access, so it holds while the server responds
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/heap_memory_server.sv
// rtl/heap_memory_server.sv - heap access responder: read/write/resize/count-greater over banked arrays
// HEAP_CLEAR_ON_RESET_EN: zero every RAM word after reset before accepting requests.
module heap_memory_server
  import heap_pkg::*;
#(
  parameter int MEMORY_ELEMENT_WIDTH = HEAP_WORD_W,
  parameter int N_AREA               = HEAP_N_AREA,
  parameter int N_ARRAYS             = HEAP_N_ARRAYS,
  parameter int ARRAY_W              = $clog2(N_ARRAYS),
  parameter int INDEX_W              = $clog2(N_AREA) + 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [1:0]                      req_op,
  input  logic [ARRAY_W-1:0]              req_array,
  input  logic [INDEX_W-1:0]              req_index,
  input  logic [MEMORY_ELEMENT_WIDTH-1:0] req_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [MEMORY_ELEMENT_WIDTH-1:0] rsp_data,
  output logic                            rsp_error
);

  localparam int W      = MEMORY_ELEMENT_WIDTH;
  localparam int DEPTH  = N_ARRAYS * N_AREA;
  localparam int ADDR_W = ARRAY_W + INDEX_W - 1;

  localparam logic [INDEX_W-1:0] AREA_IDX  = INDEX_W'(N_AREA);
  localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(N_AREA - 1);
  localparam logic [W-1:0]       AREA_DATA = W'(N_AREA);

`ifdef HEAP_CLEAR_ON_RESET_EN
  localparam heap_state_t RESET_STATE = ST_CLEAR;
`else
  localparam heap_state_t RESET_STATE = ST_IDLE;
`endif

  heap_state_t          state;
  logic                 alive;
  heap_op_t             op_q;
  logic [ARRAY_W-1:0]   arr_q;
  logic [INDEX_W-1:0]   idx_q;
  logic [W-1:0]         data_q;
  logic                 err_q;
  logic                 from_ram_q;
  logic [W-1:0]         rsp_reg;
  logic [INDEX_W-1:0]   lengths [N_ARRAYS];
  logic [INDEX_W-1:0]   scan_idx;
  logic [INDEX_W-1:0]   scan_idx_d;
  logic                 scan_vld;
  logic [INDEX_W-1:0]   count;
`ifdef HEAP_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0]    clr_addr;
`endif

  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [W-1:0]         ram_wdata;
  logic [W-1:0]         ram_rdata;

  logic                 accept;
  logic [INDEX_W-1:0]   len_q;
  logic                 hit;
  logic [INDEX_W-1:0]   count_next;

  assign req_ready  = (state == ST_IDLE) && alive;
  assign accept     = req_valid && req_ready;
  assign len_q      = lengths[arr_q];
  assign hit        = scan_vld && (scan_idx_d < len_q) && (ram_rdata > data_q);
  assign count_next = count + {{(INDEX_W-1){1'b0}}, hit};

  assign rsp_valid = (state == ST_RESPOND);
  assign rsp_error = (state == ST_RESPOND) && err_q;
  // READ data comes straight off the RAM register, which is idle (and so stable) in RESPOND
  assign rsp_data  = (state != ST_RESPOND) ? '0 : (from_ram_q ? ram_rdata : rsp_reg);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {arr_q, idx_q[INDEX_W-2:0]};
    ram_wdata = data_q;
    case (state)
      ST_ACCESS: begin
        ram_en = 1'b1;
        ram_we = (op_q == WRITE);
      end
      ST_SCAN: begin
        ram_en   = (scan_idx < AREA_IDX);
        ram_addr = {arr_q, scan_idx[INDEX_W-2:0]};
      end
`ifdef HEAP_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RESET_STATE;
      alive      <= 1'b0;
      op_q       <= READ;
      arr_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      from_ram_q <= 1'b0;
      rsp_reg    <= '0;
      scan_idx   <= '0;
      scan_idx_d <= '0;
      scan_vld   <= 1'b0;
      count      <= '0;
      for (int i = 0; i < N_ARRAYS; i++) lengths[i] <= '0;
`ifdef HEAP_CLEAR_ON_RESET_EN
      clr_addr   <= '0;
`endif
    end else begin
      alive <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= heap_op_t'(req_op);
            arr_q      <= req_array;
            idx_q      <= req_index;
            data_q     <= req_data;
            err_q      <= 1'b0;
            from_ram_q <= 1'b0;
            rsp_reg    <= '0;
            case (heap_op_t'(req_op))
              READ: begin
                if (req_index >= AREA_IDX) begin
                  err_q <= 1'b1;
                  state <= ST_RESPOND;
                end else begin
                  from_ram_q <= (req_index < lengths[req_array]);
                  state      <= ST_ACCESS;
                end
              end
              WRITE: begin
                if (req_index >= AREA_IDX) begin
                  err_q <= 1'b1;
                  state <= ST_RESPOND;
                end else begin
                  rsp_reg <= req_data;
                  state   <= ST_ACCESS;
                end
              end
              COUNT_GREATER: begin
                scan_idx <= '0;
                scan_vld <= 1'b0;
                count    <= '0;
                state    <= ST_SCAN;
              end
              RESIZE: begin
                if (req_data > AREA_DATA) begin
                  err_q <= 1'b1;
                end else begin
                  lengths[req_array] <= req_data[INDEX_W-1:0];
                  rsp_reg            <= req_data;
                end
                state <= ST_RESPOND;
              end
            endcase
          end
        end
        ST_ACCESS: begin
          if (op_q == WRITE && idx_q >= len_q) lengths[arr_q] <= idx_q + INDEX_W'(1);
          state <= ST_RESPOND;
        end
        ST_SCAN: begin
          // issue index scan_idx while scoring the word read for scan_idx_d
          scan_vld   <= (scan_idx < AREA_IDX);
          scan_idx_d <= scan_idx;
          if (scan_idx < AREA_IDX) scan_idx <= scan_idx + INDEX_W'(1);
          count <= count_next;
          if (scan_vld && scan_idx_d == LAST_IDX) begin
            rsp_reg <= {{(W-INDEX_W){1'b0}}, count_next};
            state   <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) state <= ST_IDLE;
        end
`ifdef HEAP_CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == {ADDR_W{1'b1}}) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  heap_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_heap_memory_server.sv
// tb/tb_heap_memory_server.sv - directed self-checking bench for heap_memory_server
module tb_heap_memory_server;
  import heap_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [1:0]  req_array = '0;
  logic [2:0]  req_index = '0;
  logic [11:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [11:0] rsp_data;
  logic        rsp_error;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  heap_memory_server dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_array (req_array),
    .req_index (req_index),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input heap_op_t op, input int arr, input int idx, input int data);
    logic seen;
    int   n;
    req_op    = op;
    req_array = 2'(arr);
    req_index = 3'(idx);
    req_data  = 12'(data);
    req_valid = 1'b1;
    n = 0;
    do begin
      seen = req_ready;
      @(posedge clock); #1;
      n++;
    end while (!seen && n < 100);
    req_valid = 1'b0;
    if (!seen) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input heap_op_t op, input int arr, input int idx,
                      input int data, input int exp_data, input int exp_err, input int exp_lat);
    int lat;
    send(op, arr, idx, data);
    wait_rsp(lat);
    chk({tag, "_data"}, int'(rsp_data), exp_data);
    chk({tag, "_err"}, int'(rsp_error), exp_err);
    chk({tag, "_lat"}, lat, exp_lat);
    take();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  int lat;
  int n;
  int seen_rsp;
`ifdef HEAP_CLEAR_ON_RESET_EN
  localparam int READY_DELAY = 16;
`else
  localparam int READY_DELAY = 1;
`endif

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_error", int'(rsp_error), 0);
    reset = 1'b0;
    #1;
    chk("rel_req_ready", int'(req_ready), 0);
    wait_ready(n);
    chk("ready_delay", n, READY_DELAY);

    xact("wr_a0_0", WRITE, 0, 0, 10, 10, 0, 2);
    xact("wr_a0_1", WRITE, 0, 1, 20, 20, 0, 2);
    xact("wr_a0_2", WRITE, 0, 2, 30, 30, 0, 2);
    xact("cnt_a0_15", COUNT_GREATER, 0, 0, 15, 2, 0, 6);

    xact("wr_a1_3", WRITE, 1, 3, 7, 7, 0, 2);
`ifdef HEAP_CLEAR_ON_RESET_EN
    xact("rd_a1_1_clr", READ, 1, 1, 0, 0, 0, 2);
`endif
    xact("rd_a1_3", READ, 1, 3, 0, 7, 0, 2);
    xact("rsz_a1_2", RESIZE, 1, 0, 2, 2, 0, 1);
    xact("rd_a1_3_short", READ, 1, 3, 0, 0, 0, 2);

    xact("rd_a0_oob", READ, 0, 4, 0, 0, 1, 1);
    xact("wr_a0_oob", WRITE, 0, 5, 99, 0, 1, 1);
    xact("rsz_a0_5", RESIZE, 0, 0, 5, 0, 1, 1);
    xact("cnt_a0_0", COUNT_GREATER, 0, 0, 0, 3, 0, 6);
    xact("cnt_a0_eq20", COUNT_GREATER, 0, 0, 20, 1, 0, 6);

    xact("wr_a3_max", WRITE, 3, 0, 4095, 4095, 0, 2);
    xact("cnt_a3_uns", COUNT_GREATER, 3, 0, 2047, 1, 0, 6);
    xact("rsz_a2_4", RESIZE, 2, 0, 4, 4, 0, 1);
    xact("rsz_a2_0", RESIZE, 2, 0, 0, 0, 0, 1);
    xact("cnt_a2_len0", COUNT_GREATER, 2, 0, 0, 0, 0, 6);

    // response held with a competing request offered
    send(READ, 0, 1, 0);
    wait_rsp(lat);
    chk("hold_lat", lat, 2);
    req_op    = RESIZE;
    req_array = 2'd2;
    req_data  = 12'd1;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_rsp_data", int'(rsp_data), 20);
      chk("hold_req_ready", int'(req_ready), 0);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    take();
    chk("hold_done_valid", int'(rsp_valid), 0);
    xact("hold_a2_len", RESIZE, 2, 0, 3, 3, 0, 1);

    // reset while scanning
    send(COUNT_GREATER, 0, 0, 15);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(rsp_valid), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    seen_rsp = 0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) seen_rsp++;
      @(posedge clock); #1;
    end
    chk("mid_rst_no_rsp", seen_rsp, 0);
    chk("mid_rst_ready_back", int'(req_ready), 1);
    xact("cnt_after_rst", COUNT_GREATER, 0, 0, 15, 0, 0, 6);
`ifdef HEAP_CLEAR_ON_RESET_EN
    xact("rsz_clr", RESIZE, 0, 0, 4, 4, 0, 1);
    xact("rd_clr", READ, 0, 2, 0, 0, 0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
